// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle integer multiply/divide unit for the execute stage.
// It owns the architectural HI/LO registers. MULT/MULTU take one busy cycle,
// DIV/DIVU run a 32-step radix-2 restoring divide plus one sign-fix cycle, and
// MTHI/MTLO write HI/LO directly.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; beats flush and start
//   start  request valid, sampled only while busy=0
//   op     0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6,7 no-op)
//   a      rs operand: multiplicand, dividend or MT source
//   b      rt operand: multiplier or divisor
//   flush  abort the in-flight operation; also drops a same-cycle start
//   busy   operation in flight, start ignored
//   done   one-cycle pulse after HI/LO take a MULT/DIV result
//   hi/lo  architectural HI and LO registers
module mult_div_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [5:0] LAST_ITER = 6'(DIV_ITER - 1);

  // Two's-complement negation, modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;
  logic signed [32:0] mul_a_q, mul_a_d;
  logic signed [32:0] mul_b_q, mul_b_d;
  logic [31:0]        dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [31:0]        dvs_q, dvs_d;
  logic [32:0]        rem_q, rem_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;

  logic signed [63:0] prod;
  logic [33:0]        rem_sh;
  logic [32:0]        rem_sub;
  logic               rem_ge;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;

  // Both operands are 33-bit signed, so MULTU zero-extension multiplies correctly
  // through the same signed multiplier.
  assign prod    = 64'(mul_a_q) * 64'(mul_b_q);

  // One restoring step: shift in the next dividend bit, keep the difference if it
  // did not go negative.
  assign rem_sh  = {rem_q, dvd_q[31]};
  assign rem_ge  = rem_sh >= {2'b00, dvs_q};
  assign rem_sub = rem_sh[32:0] - {1'b0, dvs_q};

  assign is_div  = (op == OP_DIV);
  assign a_neg   = is_div & a[31];
  assign b_neg   = is_div & b[31];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT: begin
              mul_a_d = {a[31], a};
              mul_b_d = {b[31], b};
              state_d = MUL;
            end
            OP_MULTU: begin
              mul_a_d = {1'b0, a};
              mul_b_d = {1'b0, b};
              state_d = MUL;
            end
            OP_DIV, OP_DIVU: begin
              dvd_d   = a_neg ? neg32(a) : a;
              dvs_d   = b_neg ? neg32(b) : b;
              rem_d   = '0;
              // With a zero divisor the raw quotient is all ones and must stay so;
              // the remainder path already returns the original dividend.
              qneg_d  = (a_neg ^ b_neg) && (b != 32'd0);
              rneg_d  = a_neg;
              cnt_d   = '0;
              state_d = DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d   = prod[63:32];
          lo_d   = prod[31:0];
          done_d = 1'b1;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_ge ? rem_sub : rem_sh[32:0];
          dvd_d = {dvd_q[30:0], rem_ge};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          lo_d   = qneg_q ? neg32(dvd_q) : dvd_q;
          hi_d   = rneg_q ? neg32(rem_q[31:0]) : rem_q[31:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: fixed vector table, hand-written sequences for
// flush/reset/ignored-start corner cases, and random operations compared with an
// arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start cycle; returns #1 after the sampling edge E0.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count busy cycles until done shows up, with a bounded wait.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) lat++;
      @(posedge clk);
      #1;
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return ux * uy;
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    int          lat;
    bit          seen;
    logic [63:0] exp;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1});
    vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        33});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33});
    vecs.push_back('{3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33});

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, seen);
      check($sformatf("vec%0d_done_seen", i), seen, 1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy_in_done", i), busy, 0);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // MTHI/MTLO write at E0 with no busy or done
    issue(3'd4, 32'h1111_1111, 32'h0);
    check("mthi_hi", hi, 32'h1111_1111);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    issue(3'd5, 32'h2222_2222, 32'h0);
    check("mtlo_lo", lo, 32'h2222_2222);

    // Flush after E10 of a DIV
    issue(3'd2, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    @(posedge clk);
    #1;
    check("flush_no_done_later", done, 0);
    check("flush_hi_kept", hi, 32'h1111_1111);
    check("flush_lo_kept", lo, 32'h2222_2222);

    // start and flush together: nothing starts, MT write dropped too
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd2; a = 32'd9; b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("startflush_busy", busy, 0);
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("startflush_mthi_hi", hi, 32'h1111_1111);

    // Invalid op is a no-op
    issue(3'd6, 32'hAAAA_AAAA, 32'h5);
    check("inv_busy", busy, 0);
    issue(3'd7, 32'hAAAA_AAAA, 32'h5);
    check("inv_busy2", busy, 0);
    check("inv_done", done, 0);
    check("inv_hi", hi, 32'h1111_1111);
    check("inv_lo", lo, 32'h2222_2222);

    // MTHI pulsed at E5 of a DIV is ignored; MTLO in the done cycle is accepted
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, seen);
    check("ign_done_seen", seen, 1);
    check("ign_remaining_lat", lat, 28);
    check("ign_hi", hi, 32'hFFFF_FFFF);
    check("ign_lo", lo, 32'hFFFF_FFFD);
    issue(3'd5, 32'h1234_5678, 32'h0);
    check("mtlo_in_done_lo", lo, 32'h1234_5678);
    check("mtlo_in_done_busy", busy, 0);
    check("mtlo_in_done_done", done, 0);

    // Flush in the done cycle leaves the committed result
    issue(3'd3, 32'd100, 32'd7);
    wait_done(lat, seen);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flushdone_hi", hi, 32'd2);
    check("flushdone_lo", lo, 32'd14);
    check("flushdone_busy", busy, 0);

    // Reset sampled at E20 of a DIV
    issue(3'd2, 32'd12345, 32'd17);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    issue(3'd1, 32'd3, 32'd5);
    wait_done(lat, seen);
    check("postreset_lat", lat, 1);
    check("postreset_hi", hi, 0);
    check("postreset_lo", lo, 15);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      exp = model(ro, ra, rb);
      issue(ro, ra, rb);
      wait_done(lat, seen);
      check($sformatf("rnd%0d_done_seen op=%0d a=%h b=%h", i, ro, ra, rb), seen, 1);
      check($sformatf("rnd%0d_latency", i), lat, (ro < 3'd2) ? 1 : 33);
      check($sformatf("rnd%0d_hilo op=%0d a=%h b=%h", i, ro, ra, rb), {hi, lo}, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle integer multiply/divide unit in the execute stage. It receives the same issued operand pair as the ALU and owns the architectural HI/LO registers that MFHI/MFLO read. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It reports busy so issue can stall, and pulses done on completion.

Parameters:
DIV_ITER, 32, number of radix-2 restoring-divide iterations; fixed at the word width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request valid; sampled only when busy=0
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 are no-ops
a  in  32  rs operand: dividend, multiplicand, or MT source
b  in  32  rt operand: divisor or multiplier
flush  in  1  abort the in-flight operation (pipeline flush or exception)
busy  out  1  an operation is in flight; new start is ignored
done  out  1  one-cycle pulse when HI/LO take a MULT/DIV result
hi  out  32  architectural HI register
lo  out  32  architectural LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, internal datapath cleared. Reset takes priority over flush and start, including mid-operation.
- States: IDLE, MUL, DIV, FIX.
- E0 is the edge at which start=1 and busy=0 are sampled.
- MTHI/MTLO: hi (or lo) <= a at E0. State stays IDLE, busy stays 0, done stays 0.
- MULT/MULTU:
  - At E0, register a and b with sign/zero extension to 33 bits; go to MUL.
  - At E1, write the 64-bit product: hi=[63:32], lo=[31:0]; go to IDLE.
  - busy=1 in the cycle between E0 and E1. done=1 in the cycle after E1.
- DIV/DIVU:
  - At E0, latch |a| and |b| (raw values for DIVU), the quotient-sign and remainder-sign flags, and clear the partial remainder; go to DIV with iteration counter=0.
  - Edges E1..E32: one restoring iteration per edge: shift the remainder left by one, bring in the next dividend bit, subtract the divisor when the difference is non-negative, and shift the quotient bit in.
  - After E32 go to FIX. At E33, negate the quotient when the operand signs differ (DIV only) and negate the remainder when the dividend is negative (DIV only). Write lo=quotient, hi=remainder; go to IDLE.
  - busy=1 in the cycles from E0 through E33. done=1 in the cycle after E33.
- Divide by zero (b=0, signed or unsigned): same 33-edge latency; result lo=32'hFFFF_FFFF, hi=a. No exception is raised.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- Arithmetic widths: product is the full 64-bit result, never truncated. Divider remainder register is 33 bits, so the subtract carry is preserved. Negation is two's complement, modulo 2^32.
- start while busy=1: ignored. No queuing, no state change.
- Invalid op (6 or 7) with start: no-op. State, busy and done unchanged.
- flush=1 in any non-IDLE state: at the next edge go to IDLE, busy=0, hi/lo unchanged, no done pulse.
- flush and start in the same cycle: flush wins, the start is dropped, including MTHI/MTLO.
- flush during the done cycle: no effect; HI/LO are already committed.
- done is never asserted while busy=1. busy falls at the same edge done rises.
- A new start is accepted in the done cycle, because busy=0 then.

Test Plan:
- MULT a=0xFFFF_FFFF b=0x0000_0002 -> busy for 1 cycle, done after E1, hi=0xFFFF_FFFF lo=0xFFFF_FFFE. MULTU with the same operands -> hi=0x0000_0001 lo=0xFFFF_FFFE.
- DIV a=0xFFFF_FFF9 (-7) b=2 -> busy for 33 cycles, done after E33, lo=0xFFFF_FFFD (-3) hi=0xFFFF_FFFF (-1). DIVU a=100 b=7 -> lo=14 hi=2.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000 hi=0. DIVU a=7 b=0 -> lo=0xFFFF_FFFF hi=7, done after E33.
- Start DIV with hi=0x1111_1111 lo=0x2222_2222; assert flush after E10 -> busy=0 next cycle, no done pulse, hi/lo unchanged. Repeat with start+flush in the same cycle -> nothing starts.
- During a DIV, pulse start with MTHI a=0xDEAD_BEEF at E5 -> ignored; DIV result is intact. After done, MTLO a=0x1234_5678 -> lo=0x1234_5678 at the next edge, busy and done stay 0.
- Assert reset at E20 of a DIV -> hi=lo=0, busy=0, done=0 next cycle. A following MULTU 3*5 -> lo=15 hi=0.
